// File: rtl/dmem_responder.sv
// Handshaked byte-addressed data memory with fixed LATENCY. One request is outstanding at a time.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned accesses respond with resp_err=1 and do not write.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_nx;
    logic [3:0]            cnt;
    logic                  accept, hs, enter_resp;
    logic                  is_byte, is_half, misal, trap, we;
    logic [ADDR_WIDTH-1:0] addr_al;
    logic [3:0]            be;
    logic [31:0]           wlane;
    logic                  l_write, l_sign, l_trap;
    logic [1:0]            l_size;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [31:0]           rword, rshift, ld_data;
    logic [7:0]            mem [2**ADDR_WIDTH];
    logic                  unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_WIDTH];
    assign accept      = req_valid && req_ready && (state == IDLE);
    assign hs          = resp_valid && resp_ready;
    // The counter runs down to 0 so resp_valid rises exactly LATENCY edges after acceptance.
    assign enter_resp  = (state == WAIT) && (cnt == 4'd0);

    always_comb begin
        is_byte = (req_size == 2'b00);
        is_half = (req_size == 2'b01);
        misal   = is_half ? req_addr[0] : (!is_byte && (req_addr[1:0] != 2'b00));
        addr_al = req_addr[ADDR_WIDTH-1:0];
        if (is_half)
            addr_al[0] = 1'b0;
        else if (!is_byte)
            addr_al[1:0] = 2'b00;
        if (is_byte) begin
            be    = 4'b0001 << addr_al[1:0];
            wlane = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            be    = addr_al[1] ? 4'b1100 : 4'b0011;
            wlane = {2{req_wdata[15:0]}};
        end else begin
            be    = 4'b1111;
            wlane = req_wdata;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = misal;
`else
    assign trap = 1'b0;
`endif
    assign we = accept && req_write && !trap;

    // RAM is deliberately not reset; stores survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[{addr_al[ADDR_WIDTH-1:2], 2'(i)}] <= wlane[8*i +: 8];
        end
    end

    always_comb begin
        rword  = {mem[{l_addr[ADDR_WIDTH-1:2], 2'd3}], mem[{l_addr[ADDR_WIDTH-1:2], 2'd2}],
                  mem[{l_addr[ADDR_WIDTH-1:2], 2'd1}], mem[{l_addr[ADDR_WIDTH-1:2], 2'd0}]};
        rshift = rword >> {l_addr[1:0], 3'b000};
        case (l_size)
            2'd0:    ld_data = {{24{l_sign & rshift[7]}}, rshift[7:0]};
            2'd1:    ld_data = {{16{l_sign & rshift[15]}}, rshift[15:0]};
            default: ld_data = rshift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b0;
            cnt        <= 4'd0;
            l_write    <= 1'b0;
            l_sign     <= 1'b0;
            l_trap     <= 1'b0;
            l_size     <= 2'd0;
            l_addr     <= '0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            req_ready <= (state_nx == IDLE);
            if (accept) begin
                cnt     <= 4'(LATENCY - 1);
                l_write <= req_write;
                l_sign  <= req_sign;
                l_trap  <= trap;
                l_size  <= is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
                l_addr  <= addr_al;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_rdata <= (l_write || l_trap) ? 32'd0 : ld_data;
                resp_err   <= l_trap;
            end else if (hs) begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes model-derived expectations,
// monitor pops and compares on each response handshake.
module tb_dmem_responder;
    localparam int LAT = 2;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write, req_sign;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        time         t;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mdl [0:4095];
    int         total = 0, bad = 0;
    int         bp_force = 0;
    bit         seen = 0, hs_seen = 0;
    time        hs_t = 0;

    dmem_responder #(.ADDR_WIDTH(12), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_sign(req_sign), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: byte array, little-endian, natural alignment by size.
    function automatic void model(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic sign,
                                  output logic [31:0] rd, output logic er);
        int a, n;
        logic [31:0] v;
        a  = int'(addr[11:0]);
        n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        rd = 32'd0;
        er = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((a % n) != 0) begin
            er = 1'b1;
            return;
        end
`endif
        a = a - (a % n);
        if (w) begin
            for (int i = 0; i < n; i++) mdl[a + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a + i];
            if (sign && n < 4 && v[8*n - 1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    task automatic issue(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sign);
        exp_t e;
        int   n;
        time  acc;
        @(negedge clk);
        req_write = w; req_addr = addr; req_wdata = wdata; req_size = size; req_sign = sign;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc = $time + 5;
        if (hs_seen) chk("idle_gap", (acc >= hs_t + 10) ? 32'd1 : 32'd0, 32'd1);
        model(w, addr, wdata, size, sign, e.rdata, e.err);
        e.t = acc + LAT * 10 + 5;
        @(posedge clk);
        q.push_back(e);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // Monitor: owns resp_ready so the handshake decision and the pop are in one place.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        end else if (resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 32'($time), 32'(q[0].t));
                    seen = 1;
                end
                chk("resp_rdata", resp_rdata, q[0].rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
                chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
                if (bp_force > 0) begin
                    resp_ready = 1'b0;
                    bp_force--;
                end else begin
                    resp_ready = ($urandom % 4) != 0;
                end
                if (resp_ready) begin
                    hs_t    = $time + 5;
                    hs_seen = 1;
                    seen    = 0;
                    void'(q.pop_front());
                end
            end
        end else begin
            chk("idle_rdata", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'd0);
            if (q.size() > 0) chk("ready_busy", {31'd0, req_ready}, 32'd0);
            resp_ready = ($urandom % 2) != 0;
        end
    end

    initial begin
        logic [31:0] tmp;
        logic [6:0]  a7;
        int          n;
        rst_n = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        req_size = 0; req_sign = 0; resp_ready = 0;
        #1 rst_n = 0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("ready_after_rel", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 128; i += 4) issue(1, 32'(i), $urandom, 2'd2, 0);

        issue(1, 32'h010, 32'hDEADBEEF, 2'd2, 0);
        issue(0, 32'h010, 32'h0, 2'd2, 0);
        issue(0, 32'h013, 32'h0, 2'd0, 1);
        issue(0, 32'h013, 32'h0, 2'd0, 0);
        issue(0, 32'h010, 32'h0, 2'd1, 1);
        issue(1, 32'h011, 32'h55, 2'd0, 0);
        issue(0, 32'h010, 32'h0, 2'd2, 0);
        issue(0, 32'h1010, 32'h0, 2'd2, 0);
        bp_force = 5;
        issue(0, 32'h010, 32'h0, 2'd3, 1);
        issue(0, 32'h014, 32'h0, 2'd2, 0);
        issue(0, 32'h012, 32'h0, 2'd2, 0);
        issue(1, 32'h022, 32'h12345678, 2'd2, 0);
        issue(0, 32'h020, 32'h0, 2'd2, 0);
        issue(0, 32'h023, 32'h0, 2'd1, 1);

        // Reset during WAIT of a load: no response, ready returns one edge after release.
        issue(0, 32'h010, 32'h0, 2'd2, 0);
        @(negedge clk);
        #2 rst_n = 0;
        q.delete();
        seen = 0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        #2 rst_n = 1;
        @(negedge clk);
        chk("midrst_ready_rel", {31'd0, req_ready}, 32'd1);
        issue(0, 32'h010, 32'h0, 2'd2, 0);

        repeat (150) begin
            tmp = $urandom;
            a7  = 7'($urandom_range(0, 127));
            if (($urandom % 8) == 0) bp_force = $urandom_range(1, 4);
            n = $urandom % 3;
            repeat (n) @(negedge clk);
            issue(1'($urandom % 2), {tmp[31:12], 5'd0, a7}, $urandom, 2'($urandom % 4), 1'($urandom % 2));
        end

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
